// File: rtl/parser_layer.sv
// rtl/parser_layer.sv - one pipelined parser layer: masked priority rule match and key field extraction
// Optional feature macro: PARSER_LAYER_TWO_CYCLE_EN (adds stage S2b between S2 and S3, latency 4).
module parser_layer #(
  parameter int HEAD_WIDTH = 1024,
  parameter int TYPE_WIDTH = 16,
  parameter int TYPE_NUM   = 2,
  parameter int KEY_WIDTH  = 16,
  parameter int KEY_NUM    = 8,
  parameter int RULE_NUM   = 16,
  localparam int TOFF_W    = $clog2(HEAD_WIDTH / TYPE_WIDTH),
  localparam int KOFF_W    = $clog2(HEAD_WIDTH / KEY_WIDTH),
  localparam int IDX_W     = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_rule_wren,
  input  logic                            i_rule_rden,
  input  logic [31:0]                     i_rule_addr,
  input  logic [31:0]                     i_rule_wdata,
  output logic                            o_rule_rdata_valid,
  output logic [31:0]                     o_rule_rdata,
  input  logic                            i_head_valid,
  output logic                            o_head_ready,
  input  logic [HEAD_WIDTH-1:0]           i_head,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [HEAD_WIDTH-1:0]           o_head,
  output logic [KEY_NUM*KEY_WIDTH-1:0]    o_meta,
  output logic                            o_hit,
  output logic [IDX_W-1:0]                o_rule_idx
);

  localparam int TF_N = HEAD_WIDTH / TYPE_WIDTH;
  localparam int KF_N = HEAD_WIDTH / KEY_WIDTH;
  localparam int TW   = TYPE_NUM * TYPE_WIDTH;
  localparam int KOW  = KEY_NUM * KOFF_W;
  localparam int MW   = KEY_NUM * KEY_WIDTH;

  // Rule table; per-rule vectors keep field 0 in the MSBs, like the header.
  logic [TOFF_W-1:0] type_off [TYPE_NUM];
  logic [RULE_NUM-1:0] rule_valid;
  logic [TW-1:0]     rule_data [RULE_NUM];
  logic [TW-1:0]     rule_mask [RULE_NUM];
  logic [KOW-1:0]    rule_koff [RULE_NUM];

  logic [7:0] cfg_region;
  logic [7:0] cfg_rule;
  logic [7:0] cfg_word;
  logic [31:0] rd_word;
  logic cfg_unused;

  assign cfg_region = i_rule_addr[31:24];
  assign cfg_rule   = i_rule_addr[15:8];
  assign cfg_word   = i_rule_addr[7:0];
  // Address bits 23:16 and the upper write-data bits carry no information.
  assign cfg_unused = ^{i_rule_addr[23:16], i_rule_wdata};

  // Configuration writes; addresses outside the map fall through untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < TYPE_NUM; t++) type_off[t] <= '0;
      rule_valid <= '0;
      for (int r = 0; r < RULE_NUM; r++) begin
        rule_data[r] <= '0;
        rule_mask[r] <= '0;
        rule_koff[r] <= '0;
      end
    end else if (i_rule_wren) begin
      if (cfg_region == 8'd0) begin
        for (int t = 0; t < TYPE_NUM; t++)
          if (cfg_word == 8'(t)) type_off[t] <= i_rule_wdata[TOFF_W-1:0];
      end else if (cfg_region == 8'd1) begin
        for (int r = 0; r < RULE_NUM; r++) begin
          if (cfg_rule == 8'(r)) begin
            if (cfg_word == 8'd0) rule_valid[r] <= i_rule_wdata[0];
            for (int t = 0; t < TYPE_NUM; t++) begin
              if (cfg_word == 8'(1 + t))
                rule_data[r][TW-1-t*TYPE_WIDTH -: TYPE_WIDTH] <= i_rule_wdata[TYPE_WIDTH-1:0];
              if (cfg_word == 8'(1 + TYPE_NUM + t))
                rule_mask[r][TW-1-t*TYPE_WIDTH -: TYPE_WIDTH] <= i_rule_wdata[TYPE_WIDTH-1:0];
            end
            for (int k = 0; k < KEY_NUM; k++)
              if (cfg_word == 8'(1 + 2*TYPE_NUM + k))
                rule_koff[r][KOW-1-k*KOFF_W -: KOFF_W] <= i_rule_wdata[KOFF_W-1:0];
          end
        end
      end
    end
  end

  // Readback mux over the current table contents, zero-extended to 32 bits.
  always_comb begin
    rd_word = '0;
    if (cfg_region == 8'd0) begin
      for (int t = 0; t < TYPE_NUM; t++)
        if (cfg_word == 8'(t)) rd_word = 32'(type_off[t]);
    end else if (cfg_region == 8'd1) begin
      for (int r = 0; r < RULE_NUM; r++) begin
        if (cfg_rule == 8'(r)) begin
          if (cfg_word == 8'd0) rd_word = 32'(rule_valid[r]);
          for (int t = 0; t < TYPE_NUM; t++) begin
            if (cfg_word == 8'(1 + t))
              rd_word = 32'(rule_data[r][TW-1-t*TYPE_WIDTH -: TYPE_WIDTH]);
            if (cfg_word == 8'(1 + TYPE_NUM + t))
              rd_word = 32'(rule_mask[r][TW-1-t*TYPE_WIDTH -: TYPE_WIDTH]);
          end
          for (int k = 0; k < KEY_NUM; k++)
            if (cfg_word == 8'(1 + 2*TYPE_NUM + k))
              rd_word = 32'(rule_koff[r][KOW-1-k*KOFF_W -: KOFF_W]);
        end
      end
    end
  end

  // Readback register: reads sample the table before a same-cycle write lands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= '0;
    end else begin
      o_rule_rdata_valid <= i_rule_rden;
      if (i_rule_rden) o_rule_rdata <= rd_word;
    end
  end

  // Stage control: a stage loads when empty or when its successor loads.
  logic s1_valid, s2_valid;
  logic s1_load, s2_load, s3_load;

  assign s3_load = ~o_valid | i_ready;
`ifdef PARSER_LAYER_TWO_CYCLE_EN
  logic s2b_valid;
  logic s2b_load;
  assign s2b_load = ~s2b_valid | s3_load;
  assign s2_load  = ~s2_valid | s2b_load;
`else
  assign s2_load  = ~s2_valid | s3_load;
`endif
  assign s1_load      = ~s1_valid | s2_load;
  assign o_head_ready = s1_load;

  // Type field view of the incoming header.
  logic [TYPE_WIDTH-1:0] in_tfield [TF_N];
  logic [TW-1:0]         in_types;

  // Slice the input header into type-width fields, field 0 at the MSB end.
  always_comb begin
    for (int f = 0; f < TF_N; f++)
      in_tfield[f] = i_head[HEAD_WIDTH-1-f*TYPE_WIDTH -: TYPE_WIDTH];
  end

  // Pick the configured type fields for matching.
  always_comb begin
    in_types = '0;
    for (int t = 0; t < TYPE_NUM; t++)
      in_types[TW-1-t*TYPE_WIDTH -: TYPE_WIDTH] = in_tfield[type_off[t]];
  end

  logic [HEAD_WIDTH-1:0] s1_head;
  logic [TW-1:0]         s1_types;

  // S1: header plus extracted type fields.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_head  <= '0;
      s1_types <= '0;
    end else if (s1_load) begin
      s1_valid <= i_head_valid;
      if (i_head_valid) begin
        s1_head  <= i_head;
        s1_types <= in_types;
      end
    end
  end

  logic             m_hit;
  logic [IDX_W-1:0] m_idx;
  logic [KOW-1:0]   m_koff;

  // Priority match: scanning downward lets the lowest matching index win.
  always_comb begin
    m_hit  = 1'b0;
    m_idx  = '0;
    m_koff = '0;
    for (int r = RULE_NUM - 1; r >= 0; r--) begin
      if (rule_valid[r] && (((s1_types ^ rule_data[r]) & rule_mask[r]) == '0)) begin
        m_hit  = 1'b1;
        m_idx  = IDX_W'(r);
        m_koff = rule_koff[r];
      end
    end
  end

  logic [HEAD_WIDTH-1:0] s2_head;
  logic                  s2_hit;
  logic [IDX_W-1:0]      s2_idx;
  logic [KOW-1:0]        s2_koff;

  // S2: header, match result and the winner's key offsets.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_head  <= '0;
      s2_hit   <= 1'b0;
      s2_idx   <= '0;
      s2_koff  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_head <= s1_head;
        s2_hit  <= m_hit;
        s2_idx  <= m_idx;
        s2_koff <= m_koff;
      end
    end
  end

  logic                  pre_valid;
  logic [HEAD_WIDTH-1:0] pre_head;
  logic                  pre_hit;
  logic [IDX_W-1:0]      pre_idx;
  logic [KOW-1:0]        pre_koff;

`ifdef PARSER_LAYER_TWO_CYCLE_EN
  logic [HEAD_WIDTH-1:0] s2b_head;
  logic                  s2b_hit;
  logic [IDX_W-1:0]      s2b_idx;
  logic [KOW-1:0]        s2b_koff;

  // S2b: extra register slice so key extraction starts from a clean flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2b_valid <= 1'b0;
      s2b_head  <= '0;
      s2b_hit   <= 1'b0;
      s2b_idx   <= '0;
      s2b_koff  <= '0;
    end else if (s2b_load) begin
      s2b_valid <= s2_valid;
      if (s2_valid) begin
        s2b_head <= s2_head;
        s2b_hit  <= s2_hit;
        s2b_idx  <= s2_idx;
        s2b_koff <= s2_koff;
      end
    end
  end

  assign pre_valid = s2b_valid;
  assign pre_head  = s2b_head;
  assign pre_hit   = s2b_hit;
  assign pre_idx   = s2b_idx;
  assign pre_koff  = s2b_koff;
`else
  assign pre_valid = s2_valid;
  assign pre_head  = s2_head;
  assign pre_hit   = s2_hit;
  assign pre_idx   = s2_idx;
  assign pre_koff  = s2_koff;
`endif

  logic [KEY_WIDTH-1:0] kfield [KF_N];
  logic [MW-1:0]        x_meta;

  // Slice the stage header into key-width fields.
  always_comb begin
    for (int f = 0; f < KF_N; f++)
      kfield[f] = pre_head[HEAD_WIDTH-1-f*KEY_WIDTH -: KEY_WIDTH];
  end

  // Gather key fields at the winning offsets; a miss yields all-zero metadata.
  always_comb begin
    x_meta = '0;
    if (pre_hit) begin
      for (int k = 0; k < KEY_NUM; k++)
        x_meta[MW-1-k*KEY_WIDTH -: KEY_WIDTH] = kfield[pre_koff[KOW-1-k*KOFF_W -: KOFF_W]];
    end
  end

  // S3: output register, held while downstream is not ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid    <= 1'b0;
      o_head     <= '0;
      o_meta     <= '0;
      o_hit      <= 1'b0;
      o_rule_idx <= '0;
    end else if (s3_load) begin
      o_valid <= pre_valid;
      if (pre_valid) begin
        o_head     <= pre_head;
        o_meta     <= x_meta;
        o_hit      <= pre_hit;
        o_rule_idx <= pre_idx;
      end
    end
  end

endmodule

// File: tb/tb_parser_layer.sv
// tb/tb_parser_layer.sv - directed self-checking bench for parser_layer
module tb_parser_layer;

  localparam int HW = 1024;
  localparam int MW = 128;
  localparam int IW = 4;
`ifdef PARSER_LAYER_TWO_CYCLE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_rule_wren, i_rule_rden;
  logic [31:0]   i_rule_addr, i_rule_wdata;
  logic          o_rule_rdata_valid;
  logic [31:0]   o_rule_rdata;
  logic          i_head_valid, o_head_ready;
  logic [HW-1:0] i_head;
  logic          o_valid, i_ready;
  logic [HW-1:0] o_head;
  logic [MW-1:0] o_meta;
  logic          o_hit;
  logic [IW-1:0] o_rule_idx;

  int pass_cnt = 0;
  int total_cnt = 0;

  parser_layer #(
    .HEAD_WIDTH(1024), .TYPE_WIDTH(16), .TYPE_NUM(2),
    .KEY_WIDTH(16), .KEY_NUM(8), .RULE_NUM(16)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_rule_wren(i_rule_wren), .i_rule_rden(i_rule_rden),
    .i_rule_addr(i_rule_addr), .i_rule_wdata(i_rule_wdata),
    .o_rule_rdata_valid(o_rule_rdata_valid), .o_rule_rdata(o_rule_rdata),
    .i_head_valid(i_head_valid), .o_head_ready(o_head_ready), .i_head(i_head),
    .o_valid(o_valid), .i_ready(i_ready), .o_head(o_head), .o_meta(o_meta),
    .o_hit(o_hit), .o_rule_idx(o_rule_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] addr(input int region, input int rule, input int word);
    return {8'(region), 8'h00, 8'(rule), 8'(word)};
  endfunction

  // Header whose 16-bit field k holds base+k, with field 6 (bytes 12-13) forced to t6.
  function automatic logic [HW-1:0] mk_head(input logic [15:0] base, input logic [15:0] t6);
    logic [HW-1:0] h;
    h = '0;
    for (int k = 0; k < 64; k++) h[HW-1-k*16 -: 16] = base + 16'(k);
    h[HW-1-6*16 -: 16] = t6;
    return h;
  endfunction

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    i_rule_wren = 1'b1; i_rule_addr = a; i_rule_wdata = d;
    @(negedge clk);
    i_rule_wren = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    i_rule_rden = 1'b1; i_rule_addr = a;
    @(negedge clk);
    i_rule_rden = 1'b0;
    v = o_rule_rdata_valid;
    d = o_rule_rdata;
  endtask

  task automatic send_beat(input logic [HW-1:0] h, output logic [HW-1:0] oh,
                           output logic [MW-1:0] om, output logic ohit,
                           output logic [IW-1:0] oidx, output int lat);
    @(negedge clk);
    i_head = h; i_head_valid = 1'b1; i_ready = 1'b1;
    @(negedge clk);
    i_head_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    oh = o_head; om = o_meta; ohit = o_hit; oidx = o_rule_idx;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid); else pass_cnt++;
    total_cnt++; if (o_head !== '0) $display("FAIL reset_head: got[1023:896]=%h want 0", o_head[HW-1 -: 128]); else pass_cnt++;
    total_cnt++; if (o_meta !== '0) $display("FAIL reset_meta: got %h want 0", o_meta); else pass_cnt++;
    total_cnt++; if ({o_hit, o_rule_idx} !== 5'd0) $display("FAIL reset_hit_idx: got %b/%0d want 0/0", o_hit, o_rule_idx); else pass_cnt++;
    total_cnt++; if ({o_rule_rdata_valid, o_rule_rdata} !== 33'd0) $display("FAIL reset_rdata: got %b/%h want 0/0", o_rule_rdata_valid, o_rule_rdata); else pass_cnt++;
    total_cnt++; if (o_head_ready !== 1'b1) $display("FAIL reset_head_ready: got %b want 1", o_head_ready); else pass_cnt++;
  endtask

  task automatic test_eth_hit();
    logic [HW-1:0] h, oh; logic [MW-1:0] om; logic ohit; logic [IW-1:0] oidx; int lat;
    cfg_write(addr(0, 0, 0), 32'd6);
    cfg_write(addr(1, 0, 1), 32'h0800);
    cfg_write(addr(1, 0, 3), 32'hFFFF);
    cfg_write(addr(1, 0, 4), 32'h0000);
    for (int k = 0; k < 8; k++) cfg_write(addr(1, 0, 5 + k), 32'(7 + k));
    cfg_write(addr(1, 0, 0), 32'd1);
    h = mk_head(16'hA000, 16'h0800);
    send_beat(h, oh, om, ohit, oidx, lat);
    total_cnt++; if (lat !== LAT) $display("FAIL eth_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if (ohit !== 1'b1) $display("FAIL eth_hit: got %b want 1", ohit); else pass_cnt++;
    total_cnt++; if (oidx !== 4'd0) $display("FAIL eth_idx: got %0d want 0", oidx); else pass_cnt++;
    total_cnt++; if (om !== 128'hA007_A008_A009_A00A_A00B_A00C_A00D_A00E) $display("FAIL eth_meta: got %h want a007a008a009a00aa00ba00ca00da00e", om); else pass_cnt++;
    total_cnt++; if (oh !== h) $display("FAIL eth_head: got[1023:896]=%h want %h", oh[HW-1 -: 128], h[HW-1 -: 128]); else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [HW-1:0] oh; logic [MW-1:0] om; logic ohit; logic [IW-1:0] oidx; int lat;
    cfg_write(addr(1, 2, 1), 32'h0806);
    cfg_write(addr(1, 2, 3), 32'hFFFF);
    cfg_write(addr(1, 2, 0), 32'd1);
    cfg_write(addr(1, 5, 0), 32'd1);
    send_beat(mk_head(16'hB000, 16'h0806), oh, om, ohit, oidx, lat);
    total_cnt++; if ({ohit, oidx} !== {1'b1, 4'd2}) $display("FAIL prio_2_over_5: got %b/%0d want 1/2", ohit, oidx); else pass_cnt++;
    total_cnt++; if (om !== {8{16'hB000}}) $display("FAIL prio_meta_off0: got %h want b000 x8", om); else pass_cnt++;
    send_beat(mk_head(16'hB100, 16'h0800), oh, om, ohit, oidx, lat);
    total_cnt++; if ({ohit, oidx} !== {1'b1, 4'd0}) $display("FAIL prio_0_over_5: got %b/%0d want 1/0", ohit, oidx); else pass_cnt++;
    total_cnt++; if (om !== 128'hB107_B108_B109_B10A_B10B_B10C_B10D_B10E) $display("FAIL prio_meta_rule0: got %h want b107..b10e", om); else pass_cnt++;
    cfg_write(addr(1, 2, 0), 32'd0);
    send_beat(mk_head(16'hB200, 16'h0806), oh, om, ohit, oidx, lat);
    total_cnt++; if ({ohit, oidx} !== {1'b1, 4'd5}) $display("FAIL prio_after_invalidate: got %b/%0d want 1/5", ohit, oidx); else pass_cnt++;
    cfg_write(addr(1, 5, 0), 32'd0);
  endtask

  task automatic test_miss();
    logic [HW-1:0] h, oh; logic [MW-1:0] om; logic ohit; logic [IW-1:0] oidx; int lat;
    h = mk_head(16'hC000, 16'h86DD);
    send_beat(h, oh, om, ohit, oidx, lat);
    total_cnt++; if ({ohit, oidx} !== 5'd0) $display("FAIL miss_hit_idx: got %b/%0d want 0/0", ohit, oidx); else pass_cnt++;
    total_cnt++; if (om !== '0) $display("FAIL miss_meta: got %h want 0", om); else pass_cnt++;
    total_cnt++; if (oh !== h) $display("FAIL miss_head: got[1023:896]=%h want %h", oh[HW-1 -: 128], h[HW-1 -: 128]); else pass_cnt++;
  endtask

  task automatic test_readback();
    logic [31:0] d; logic v;
    cfg_write(addr(1, 3, 1), 32'h0000_1234);
    cfg_read(addr(1, 3, 1), d, v);
    total_cnt++; if ({v, d} !== {1'b1, 32'h0000_1234}) $display("FAIL rb_rule3_w1: got %b/%h want 1/00001234", v, d); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (o_rule_rdata_valid !== 1'b0) $display("FAIL rb_valid_drop: got %b want 0", o_rule_rdata_valid); else pass_cnt++;
    cfg_read(addr(2, 0, 0), d, v);
    total_cnt++; if ({v, d} !== {1'b1, 32'h0}) $display("FAIL rb_unmapped_region: got %b/%h want 1/0", v, d); else pass_cnt++;
    cfg_read(addr(1, 3, 200), d, v);
    total_cnt++; if ({v, d} !== {1'b1, 32'h0}) $display("FAIL rb_unmapped_word: got %b/%h want 1/0", v, d); else pass_cnt++;
    cfg_read(addr(0, 0, 0), d, v);
    total_cnt++; if (d !== 32'd6) $display("FAIL rb_type_off0: got %h want 6", d); else pass_cnt++;
    cfg_write(addr(1, 3, 2), 32'hFFFF_4321);
    cfg_read(addr(1, 3, 2), d, v);
    total_cnt++; if (d !== 32'h0000_4321) $display("FAIL rb_zero_extend: got %h want 00004321", d); else pass_cnt++;
    @(negedge clk);
    i_rule_wren = 1'b1; i_rule_rden = 1'b1; i_rule_addr = addr(1, 3, 1); i_rule_wdata = 32'h5678;
    @(negedge clk);
    i_rule_wren = 1'b0; i_rule_rden = 1'b0;
    total_cnt++; if (o_rule_rdata !== 32'h0000_1234) $display("FAIL rb_same_cycle_old: got %h want 00001234", o_rule_rdata); else pass_cnt++;
    cfg_read(addr(1, 3, 1), d, v);
    total_cnt++; if (d !== 32'h0000_5678) $display("FAIL rb_after_write: got %h want 00005678", d); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [HW-1:0] sent [10];
    logic [HW-1:0] prev_head;
    logic prev_stall, acc, del, saw_block;
    int si, ri, occ, hr_bad, stall_bad, order_bad, extra;
    for (int i = 0; i < 10; i++) sent[i] = mk_head(16'((i + 1) * 256), 16'h0000);
    si = 0; ri = 0; occ = 0; hr_bad = 0; stall_bad = 0; order_bad = 0; extra = 0;
    prev_stall = 1'b0; saw_block = 1'b0; prev_head = '0;
    for (int c = 0; c < 60 && ri < 10; c++) begin
      @(negedge clk);
      i_ready = !(c >= 4 && c <= 9);
      i_head_valid = (si < 10);
      if (si < 10) i_head = sent[si];
      #1;
      if (o_head_ready !== !(occ == LAT && !i_ready)) hr_bad++;
      if (!o_head_ready) saw_block = 1'b1;
      if (prev_stall && (o_valid !== 1'b1 || o_head !== prev_head)) stall_bad++;
      prev_stall = o_valid && !i_ready;
      prev_head = o_head;
      acc = i_head_valid && o_head_ready;
      del = o_valid && i_ready;
      if (del) begin
        if (ri >= 10) order_bad++;
        else if (o_head !== sent[ri]) order_bad++;
        ri++;
      end
      if (acc) si++;
      occ = occ + int'(acc) - int'(del);
    end
    @(negedge clk);
    i_head_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (o_valid) extra++;
      @(negedge clk);
    end
    total_cnt++; if (ri !== 10) $display("FAIL bp_received: got %0d want 10", ri); else pass_cnt++;
    total_cnt++; if (si !== 10) $display("FAIL bp_accepted: got %0d want 10", si); else pass_cnt++;
    total_cnt++; if (order_bad !== 0) $display("FAIL bp_order: got %0d bad beats want 0", order_bad); else pass_cnt++;
    total_cnt++; if (extra !== 0) $display("FAIL bp_duplicates: got %0d extra beats want 0", extra); else pass_cnt++;
    total_cnt++; if (hr_bad !== 0) $display("FAIL bp_head_ready_rule: got %0d bad cycles want 0", hr_bad); else pass_cnt++;
    total_cnt++; if (saw_block !== 1'b1) $display("FAIL bp_head_ready_fell: got %b want 1", saw_block); else pass_cnt++;
    total_cnt++; if (stall_bad !== 0) $display("FAIL bp_stall_stable: got %0d bad cycles want 0", stall_bad); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [HW-1:0] oh; logic [MW-1:0] om; logic ohit; logic [IW-1:0] oidx; int lat;
    logic [31:0] d; logic v;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_head_valid = 1'b1;
      i_head = mk_head(16'(16'hD000 + i * 256), 16'h0800);
    end
    @(negedge clk);
    i_head_valid = 1'b0;
    total_cnt++; if ({o_valid, o_hit} !== 2'b11) $display("FAIL rstmid_pre_full: got %b%b want 11", o_valid, o_hit); else pass_cnt++;
    #2 i_rst_n = 1'b0;
    #1;
    total_cnt++; if ({o_valid, o_hit, o_rule_idx} !== 6'd0) $display("FAIL rstmid_ctrl: got %b/%b/%0d want 0/0/0", o_valid, o_hit, o_rule_idx); else pass_cnt++;
    total_cnt++; if (o_head !== '0 || o_meta !== '0) $display("FAIL rstmid_data: got head[1023:896]=%h meta=%h want 0", o_head[HW-1 -: 128], o_meta); else pass_cnt++;
    @(negedge clk);
    i_rst_n = 1'b1; i_ready = 1'b1;
    cfg_read(addr(1, 0, 0), d, v);
    total_cnt++; if (d !== 32'd0) $display("FAIL rstmid_rule_cleared: got %h want 0", d); else pass_cnt++;
    cfg_read(addr(0, 0, 0), d, v);
    total_cnt++; if (d !== 32'd0) $display("FAIL rstmid_offset_cleared: got %h want 0", d); else pass_cnt++;
    send_beat(mk_head(16'hE000, 16'h0800), oh, om, ohit, oidx, lat);
    total_cnt++; if (lat !== LAT) $display("FAIL rstmid_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
    total_cnt++; if ({ohit, oidx} !== 5'd0 || om !== '0) $display("FAIL rstmid_next_miss: got %b/%0d/%h want 0/0/0", ohit, oidx, om); else pass_cnt++;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_rule_wren = 1'b0; i_rule_rden = 1'b0; i_rule_addr = '0; i_rule_wdata = '0;
    i_head_valid = 1'b0; i_head = '0; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    test_reset();
    test_eth_hit();
    test_priority();
    test_miss();
    test_readback();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parser_layer.md
# parser_layer

Parametrised single layer of the pipelined packet parser with a valid/ready handshake. It extracts up to TYPE_NUM type fields from the header and matches them against a masked, priority-ordered rule table. The winning rule's offsets select KEY_NUM key fields, which are emitted as metadata alongside the unmodified header. Layers chain head-to-tail, the output of one driving the input of the next, and a 32-bit configuration bus writes and reads back rules at run time.

## Interface
- HEAD_WIDTH, 1024: header bits per beat. HEAD_WIDTH/TYPE_WIDTH and HEAD_WIDTH/KEY_WIDTH are powers of two.
- TYPE_WIDTH, 16: type field width, ≤32.
- TYPE_NUM, 2: type fields matched per rule.
- KEY_WIDTH, 16: key field width, ≤32.
- KEY_NUM, 8: key fields extracted.
- RULE_NUM, 16: rule entries, ≤256.
- Derived: TOFF_W = $clog2(HEAD_WIDTH/TYPE_WIDTH); KOFF_W = $clog2(HEAD_WIDTH/KEY_WIDTH); IDX_W = max(1, $clog2(RULE_NUM)).
- i_clk  in  1  single clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rule_wren / i_rule_rden  in  1  config write / read strobe.
- i_rule_addr  in  32  config address.
- i_rule_wdata  in  32  config write data.
- o_rule_rdata_valid  out  1  readback valid.
- o_rule_rdata  out  32  readback data.
- i_head_valid  in  1  input header valid.
- o_head_ready  out  1  input accepted when high together with i_head_valid.
- i_head  in  HEAD_WIDTH  input header.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream ready.
- o_head  out  HEAD_WIDTH  header passed through.
- o_meta  out  KEY_NUM*KEY_WIDTH  key fields; key 0 in the MSBs.
- o_hit  out  1  a rule matched.
- o_rule_idx  out  IDX_W  index of the matching rule; 0 on miss.

## Operation
- **Field indexing:** field k of width W is head[HEAD_WIDTH-1-k*W -: W], MSB-first.
- **Config address map:** region is addr[31:24]; addr[15:8] is the rule index; addr[7:0] is the word.
  - Region 0: word t < TYPE_NUM is type offset t, held in wdata[TOFF_W-1:0].
  - Region 1, word 0: rule valid, wdata[0].
  - Region 1, words 1..TYPE_NUM: type data.
  - Region 1, words TYPE_NUM+1..2·TYPE_NUM: type mask.
  - Region 1, next KEY_NUM words: key offsets.
- **Writes:** unmapped writes are ignored. Software clears a rule's valid bit before editing the rule.
- **Reads:** o_rule_rdata_valid asserts one cycle after i_rule_rden. Data is zero-extended; unmapped addresses read 0. If a write and a read hit the same cycle, the read returns the old value.
- **Match:** rule r hits when it is valid and ((type_t ^ data_t) & mask_t) == 0 for every t. The lowest-index hit wins.
- **Miss:** o_hit=0, o_rule_idx=0, o_meta all zero.
- **Pipeline:**
  - S1 registers the header and the extracted type fields.
  - S2 registers the header, hit, index and key offsets.
  - S3 registers the header, o_meta, o_hit and o_rule_idx.
- **Flow control:** stage n loads when it is empty or stage n+1 loads, with i_ready acting as the load of the stage after S3. o_head_ready = ~s1_valid | s2_load.
- **Stall:** a stalled stage holds all of its contents.
- **Config timing:** a rule or offset write is visible to any beat entering S1 (offsets) or S2 (rules) on the following cycle.

## Timing
- **Reset:** all valids low, o_head/o_meta/o_hit/o_rule_idx = 0, o_rule_rdata_valid = 0, o_rule_rdata = 0. All rules invalid, all offsets 0.
- **Reset mid-operation:** in-flight beats are discarded.
- **Latency:** 3 cycles from accept to o_valid with i_ready held high.
- **Throughput:** one beat per cycle.
- **Backpressure:** with i_ready low, o_valid and all output data stay stable. o_head_ready falls only when S1, S2 and S3 are all full.
- **Release:** data resumes on the cycle i_ready rises, with no bubble and no loss.
- **Readback:** 1-cycle latency, independent of data stalls.

## Configuration
- PARSER_LAYER_TWO_CYCLE_EN defined: adds stage S2b between S2 and S3, registering the key offsets and the header, with the same load rule as the other stages. Latency becomes 4 and the pipeline holds 4 beats.
- PARSER_LAYER_TWO_CYCLE_EN undefined: S2 feeds S3 directly, latency 3.

## Test plan
- **Ethernet/IPv4 hit:** type offset 0 = 6, type mask 1 = 0. Rule 0: data0 0x0800, mask0 0xFFFF, key offsets 7..14, valid. Header with bytes 12-13 = 0x0800 -> after 3 cycles o_hit=1, o_rule_idx=0, o_meta = header fields 7..14.
- **Priority:** rules 2 and 5 both match (rule 5 fully masked) -> o_rule_idx=2. Invalidate rule 2 -> o_rule_idx=5.
- **Miss:** type 0x86DD with only rule 0 valid -> o_hit=0, o_meta=0, header unchanged.
- **Backpressure:** stream 10 beats with i_ready low for cycles 4-9 -> no loss, no duplicates, order kept, o_head_ready low only while S1-S3 are all full.
- **Readback:** write rule 3 word 1 = 0x1234, then read it -> o_rule_rdata_valid and 0x00001234 one cycle later. Unmapped address -> 0.
- **Reset mid-stream:** assert i_rst_n low with 3 beats in flight -> outputs 0 immediately, rules cleared, next input miss.
